// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared types and default widths for the fft_8point_dft requester scheduler
package fft_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  typedef logic req_id_t;
  localparam int C_TDATA_W = 64;
  localparam int C_TOUT_W = 512;
  localparam int C_MAX_INFLIGHT_DEF = 8;
endpackage

// File: rtl/fft_sched_tag_fifo.sv
// fft_sched_tag_fifo: 1-bit requester-id FIFO recording the issue order of frames inside the core
module fft_sched_tag_fifo
  import fft_sched_pkg::*;
#(
  parameter int C_DEPTH = C_MAX_INFLIGHT_DEF
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_push,
  input  req_id_t i_tag,
  input  logic    i_pop,
  output logic    o_empty,
  output logic    o_full,
  output req_id_t o_head
);
  localparam int AW = $clog2(C_DEPTH);
  logic [AW:0] r_wr, r_rd;
  logic [C_DEPTH-1:0] r_mem;
  logic w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head = r_mem[r_rd[AW-1:0]];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  // read/write pointers with a wrap bit to tell full from empty
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  // tag storage; stale entries are masked by the empty flag so no reset is needed
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_tag;
endmodule

// File: rtl/fft_8point_sched.sv
// fft_8point_sched: round-robin packet scheduler sharing one FFT core between two AXIS requesters (optional FFT_SCHED_STATS_EN)
module fft_8point_sched
  import fft_sched_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = C_TDATA_W,
  parameter int C_AXIS_TOUT_WIDTH = C_TOUT_W,
  parameter int C_MAX_INFLIGHT = C_MAX_INFLIGHT_DEF
) (
  input  logic                                s_axis_aclk,
  input  logic                                s_axis_aresetn,
  input  logic                                s0_axis_tvalid,
  output logic                                s0_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]       s0_axis_tdata,
  input  logic                                s0_axis_tlast,
  input  logic                                s1_axis_tvalid,
  output logic                                s1_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]       s1_axis_tdata,
  input  logic                                s1_axis_tlast,
  output logic                                c_axis_tvalid,
  input  logic                                c_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]       c_axis_tdata,
  input  logic                                c_r_axis_tvalid,
  output logic                                c_r_axis_tready,
  input  logic [C_AXIS_TOUT_WIDTH-1:0]        c_r_axis_tdata,
  output logic                                m0_axis_tvalid,
  input  logic                                m0_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]        m0_axis_tdata,
  output logic                                m1_axis_tvalid,
  input  logic                                m1_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]        m1_axis_tdata,
  output logic [$clog2(C_MAX_INFLIGHT):0]     inflight,
  output logic                                err_orphan
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]                         stat_frames0,
  output logic [15:0]                         stat_frames1
`endif
);
  localparam int IW = $clog2(C_MAX_INFLIGHT) + 1;
  state_t r_state, w_next;
  logic r_rr, r_err;
  logic [IW-1:0] r_inflight;
  logic w_credit, w_issue, w_last, w_pop, w_empty, w_full;
  req_id_t w_head;
  assign w_credit = (r_inflight < IW'(C_MAX_INFLIGHT)) & ~w_full;
  assign inflight = r_inflight;
  assign err_orphan = r_err;
  fft_sched_tag_fifo #(.C_DEPTH(C_MAX_INFLIGHT)) u_tag_fifo (
    .i_clk   (s_axis_aclk),
    .i_rst_n (s_axis_aresetn),
    .i_push  (w_issue),
    .i_tag   (r_state == GRANT1),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_head  (w_head)
  );
  // issue mux: forward the granted requester to the core while credits remain
  always_comb begin
    c_axis_tdata = (r_state == GRANT1) ? s1_axis_tdata : s0_axis_tdata;
    w_last = (r_state == GRANT1) ? s1_axis_tlast : s0_axis_tlast;
    c_axis_tvalid = w_credit & ((r_state == GRANT0) ? s0_axis_tvalid :
                                (r_state == GRANT1) ? s1_axis_tvalid : 1'b0);
    s0_axis_tready = (r_state == GRANT0) & c_axis_tready & w_credit;
    s1_axis_tready = (r_state == GRANT1) & c_axis_tready & w_credit;
    w_issue = c_axis_tvalid & c_axis_tready;
  end
  // next grant: arbitrate from IDLE, hold the grant until the packet's last beat issues
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (s0_axis_tvalid & (~s1_axis_tvalid | ~r_rr)) w_next = GRANT0;
        else if (s1_axis_tvalid) w_next = GRANT1;
      end
      GRANT0, GRANT1: if (w_issue & w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state register and round-robin pointer favouring the requester not just served
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      r_state <= IDLE;
      r_rr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue & w_last) r_rr <= (r_state == GRANT0);
    end
  // result demux: head tag picks the destination, results with no tag are drained
  always_comb begin
    m0_axis_tdata = c_r_axis_tdata;
    m1_axis_tdata = c_r_axis_tdata;
    m0_axis_tvalid = c_r_axis_tvalid & ~w_empty & ~w_head;
    m1_axis_tvalid = c_r_axis_tvalid & ~w_empty & w_head;
    c_r_axis_tready = w_empty ? c_r_axis_tvalid : (w_head ? m1_axis_tready : m0_axis_tready);
    w_pop = c_r_axis_tvalid & c_r_axis_tready & ~w_empty;
  end
  // credit counter and sticky orphan flag
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      r_inflight <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_issue != w_pop) r_inflight <= w_issue ? r_inflight + IW'(1) : r_inflight - IW'(1);
      if (c_r_axis_tvalid & w_empty) r_err <= 1'b1;
    end
`ifdef FFT_SCHED_STATS_EN
  logic [15:0] r_st0, r_st1;
  assign stat_frames0 = r_st0;
  assign stat_frames1 = r_st1;
  // saturating per-requester delivered-result counters
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      r_st0 <= '0;
      r_st1 <= '0;
    end else begin
      if (m0_axis_tvalid & m0_axis_tready & ~&r_st0) r_st0 <= r_st0 + 16'd1;
      if (m1_axis_tvalid & m1_axis_tready & ~&r_st1) r_st1 <= r_st1 + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fft_8point_sched.sv
// tb_fft_8point_sched: scoreboard bench with a queue-based core stand-in and per-requester expected result streams
module tb_fft_8point_sched;
  logic clk = 1'b0;
  logic s_axis_aresetn = 1'b0;
  logic s0_axis_tvalid = 0, s0_axis_tready, s0_axis_tlast = 0;
  logic s1_axis_tvalid = 0, s1_axis_tready, s1_axis_tlast = 0;
  logic [63:0] s0_axis_tdata = '0, s1_axis_tdata = '0, c_axis_tdata;
  logic c_axis_tvalid, c_axis_tready = 0;
  logic c_r_axis_tvalid = 0, c_r_axis_tready;
  logic [511:0] c_r_axis_tdata = '0, m0_axis_tdata, m1_axis_tdata;
  logic m0_axis_tvalid, m0_axis_tready = 0, m1_axis_tvalid, m1_axis_tready = 0;
  logic [3:0] inflight;
  logic err_orphan;
`ifdef FFT_SCHED_STATS_EN
  logic [15:0] stat_frames0, stat_frames1;
`endif

  fft_8point_sched dut (
    .s_axis_aclk(clk), .s_axis_aresetn(s_axis_aresetn),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tlast(s1_axis_tlast),
    .c_axis_tvalid(c_axis_tvalid), .c_axis_tready(c_axis_tready), .c_axis_tdata(c_axis_tdata),
    .c_r_axis_tvalid(c_r_axis_tvalid), .c_r_axis_tready(c_r_axis_tready), .c_r_axis_tdata(c_r_axis_tdata),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready), .m0_axis_tdata(m0_axis_tdata),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready), .m1_axis_tdata(m1_axis_tdata),
    .inflight(inflight), .err_orphan(err_orphan)
`ifdef FFT_SCHED_STATS_EN
    , .stat_frames0(stat_frames0), .stat_frames1(stat_frames1)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [63:0] sq0[$], sq1[$], core_q[$], e0[$], e1[$];
  bit sl0[$], sl1[$];
  bit hs0, hs1, hsr, in_pkt, owner, want_v, want_id;
  int gap_pct, cr_pct, core_pct, m0_pct, m1_pct;
  int exp_inf, cnt0, cnt1, n_iss, seqno;
  logic [31:0] seq;

  typedef struct {
    int n0; int l0; int n1; int l1; logic [31:0] seq;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_frames(input bit id, input int n, input int l);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      d = {id, seqno[14:0], 16'h5A5A, $urandom};
      seqno++;
      if (id) begin sq1.push_back(d); sl1.push_back((i % l) == l - 1 || i == n - 1); end
      else begin sq0.push_back(d); sl0.push_back((i % l) == l - 1 || i == n - 1); end
    end
  endtask

  task automatic do_reset();
    s_axis_aresetn = 0;
    s0_axis_tvalid = 0; s1_axis_tvalid = 0; c_r_axis_tvalid = 0;
    c_axis_tready = 0; m0_axis_tready = 0; m1_axis_tready = 0;
    sq0.delete(); sq1.delete(); sl0.delete(); sl1.delete();
    core_q.delete(); e0.delete(); e1.delete();
    hs0 = 0; hs1 = 0; hsr = 0; in_pkt = 0; want_v = 0;
    exp_inf = 0; cnt0 = 0; cnt1 = 0; n_iss = 0; seq = '0;
    repeat (2) @(posedge clk);
    #3 s_axis_aresetn = 1;
    @(posedge clk); #1;
  endtask

  // observe one cycle mid-way between edges and update the scoreboard
  task automatic sample();
    logic [63:0] x;
    bit id, lst;
    chk(!(m0_axis_tvalid && m1_axis_tvalid), "m_onehot", {m0_axis_tvalid, m1_axis_tvalid}, 0);
    chk(int'(inflight) == exp_inf, "inflight", inflight, exp_inf);
    if (c_axis_tvalid && c_axis_tready) begin
      id = c_axis_tdata[63];
      lst = id ? s1_axis_tlast : s0_axis_tlast;
      chk(c_axis_tdata == (id ? s1_axis_tdata : s0_axis_tdata) &&
          (id ? (s1_axis_tvalid && s1_axis_tready && !s0_axis_tready)
              : (s0_axis_tvalid && s0_axis_tready && !s1_axis_tready)),
          "issue_src", c_axis_tdata, id ? s1_axis_tdata : s0_axis_tdata);
      chk(exp_inf < 8, "credit", exp_inf, 8);
      if (in_pkt) chk(id == owner, "atomic", id, owner);
      else if (want_v) chk(id == want_id, "rr_order", id, want_id);
      want_v = 0;
      in_pkt = !lst;
      owner = id;
      if (lst && (id ? s0_axis_tvalid : s1_axis_tvalid)) begin want_v = 1; want_id = !id; end
      if (n_iss < 32) seq[n_iss] = id;
      n_iss++;
      core_q.push_back(c_axis_tdata);
      if (id) e1.push_back(c_axis_tdata); else e0.push_back(c_axis_tdata);
      exp_inf++;
    end
    if (c_r_axis_tvalid && c_r_axis_tready) begin
      hsr = 1;
      if (core_q.size() > 0) void'(core_q.pop_front());
    end
    if (m0_axis_tvalid && m0_axis_tready) begin
      if (e0.size() == 0) chk(0, "m0_unexpected", m0_axis_tdata[63:0], 0);
      else begin x = e0.pop_front(); chk(m0_axis_tdata == {8{x}}, "m0_data", m0_axis_tdata[63:0], x); end
      exp_inf--; cnt0++;
    end
    if (m1_axis_tvalid && m1_axis_tready) begin
      if (e1.size() == 0) chk(0, "m1_unexpected", m1_axis_tdata[63:0], 0);
      else begin x = e1.pop_front(); chk(m1_axis_tdata == {8{x}}, "m1_data", m1_axis_tdata[63:0], x); end
      exp_inf--; cnt1++;
    end
    if (s0_axis_tvalid && s0_axis_tready) begin hs0 = 1; void'(sq0.pop_front()); void'(sl0.pop_front()); end
    if (s1_axis_tvalid && s1_axis_tready) begin hs1 = 1; void'(sq1.pop_front()); void'(sl1.pop_front()); end
  endtask

  // drive sources, core stand-in and sinks for one cycle
  task automatic cycle();
    if (hs0) s0_axis_tvalid = 0;
    if (hs1) s1_axis_tvalid = 0;
    if (hsr) c_r_axis_tvalid = 0;
    hs0 = 0; hs1 = 0; hsr = 0;
    if (!s0_axis_tvalid && sq0.size() > 0 && $urandom_range(99) >= gap_pct) s0_axis_tvalid = 1;
    if (s0_axis_tvalid) begin s0_axis_tdata = sq0[0]; s0_axis_tlast = sl0[0]; end
    if (!s1_axis_tvalid && sq1.size() > 0 && $urandom_range(99) >= gap_pct) s1_axis_tvalid = 1;
    if (s1_axis_tvalid) begin s1_axis_tdata = sq1[0]; s1_axis_tlast = sl1[0]; end
    if (!c_r_axis_tvalid && core_q.size() > 0 && $urandom_range(99) < cr_pct) c_r_axis_tvalid = 1;
    if (c_r_axis_tvalid) c_r_axis_tdata = {8{core_q[0]}};
    c_axis_tready = $urandom_range(99) < core_pct;
    m0_axis_tready = $urandom_range(99) < m0_pct;
    m1_axis_tready = $urandom_range(99) < m1_pct;
    #4;
    sample();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || e0.size() > 0 || e1.size() > 0) && k < bound) begin
      cycle();
      k++;
    end
    if (k >= bound) chk(0, "drain_timeout", k, bound);
  endtask

  task automatic set_pct(input int g, input int c, input int r, input int a, input int b);
    gap_pct = g; core_pct = c; cr_pct = r; m0_pct = a; m1_pct = b;
  endtask

  initial begin
    int t0, t1;
    tbl[0] = '{3, 1, 0, 1, 32'h0};
    tbl[1] = '{2, 1, 2, 1, 32'hA};
    tbl[2] = '{4, 4, 2, 1, 32'h30};
    tbl[3] = '{0, 1, 3, 1, 32'h7};
    tbl[4] = '{3, 1, 3, 3, 32'hE};
    tbl[5] = '{2, 2, 2, 2, 32'hC};
    seqno = 0;
    do_reset();
    chk(inflight == 0 && err_orphan == 0, "reset_regs", {inflight, err_orphan}, 0);
    chk({c_axis_tvalid, s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, c_r_axis_tready} == 6'b0,
        "reset_hs", {c_axis_tvalid, s0_axis_tready, s1_axis_tready, m0_axis_tvalid, m1_axis_tvalid, c_r_axis_tready}, 0);

    foreach (tbl[i]) begin
      do_reset();
      set_pct(0, 100, 100, 100, 100);
      add_frames(0, tbl[i].n0, tbl[i].l0);
      add_frames(1, tbl[i].n1, tbl[i].l1);
      drain(500);
      chk(seq == tbl[i].seq && n_iss == tbl[i].n0 + tbl[i].n1, $sformatf("order[%0d]", i), seq, tbl[i].seq);
      chk(cnt0 == tbl[i].n0 && cnt1 == tbl[i].n1, $sformatf("routing[%0d]", i), {cnt0[31:0], cnt1[31:0]},
          {tbl[i].n0[31:0], tbl[i].n1[31:0]});
      chk(inflight == 0, $sformatf("idle_inflight[%0d]", i), inflight, 0);
    end

    do_reset();
    set_pct(0, 100, 100, 0, 100);
    add_frames(0, 10, 1);
    repeat (30) cycle();
    chk(n_iss == 8, "credit_issued", n_iss, 8);
    chk(inflight == 8, "credit_inflight", inflight, 8);
    chk(s0_axis_tvalid && !s0_axis_tready, "credit_stall", {s0_axis_tvalid, s0_axis_tready}, 2'b10);
    m0_pct = 100;
    drain(200);
    chk(n_iss == 10 && cnt0 == 10, "credit_resume", {n_iss[31:0], cnt0[31:0]}, {32'd10, 32'd10});

    do_reset();
    c_r_axis_tvalid = 1;
    c_r_axis_tdata = '1;
    #4;
    chk(c_r_axis_tready == 1, "orphan_drop", c_r_axis_tready, 1);
    chk(!m0_axis_tvalid && !m1_axis_tvalid, "orphan_mvalid", {m0_axis_tvalid, m1_axis_tvalid}, 0);
    @(posedge clk); #1;
    c_r_axis_tvalid = 0;
    chk(err_orphan == 1, "orphan_set", err_orphan, 1);
    repeat (5) @(posedge clk);
    #1 chk(err_orphan == 1, "orphan_sticky", err_orphan, 1);
    do_reset();
    chk(err_orphan == 0, "orphan_clear", err_orphan, 0);

    set_pct(0, 100, 100, 0, 100);
    add_frames(0, 5, 1);
    repeat (20) cycle();
    chk(inflight == 5, "pre_reset_inflight", inflight, 5);
    s_axis_aresetn = 0;
    c_r_axis_tvalid = 0;
    s0_axis_tvalid = 0;
    @(posedge clk); #1;
    chk(inflight == 0, "midreset_inflight", inflight, 0);
    chk({c_axis_tvalid, m0_axis_tvalid, m1_axis_tvalid, s0_axis_tready} == 4'b0, "midreset_valid",
        {c_axis_tvalid, m0_axis_tvalid, m1_axis_tvalid, s0_axis_tready}, 0);
`ifdef FFT_SCHED_STATS_EN
    chk(stat_frames0 == 0 && stat_frames1 == 0, "midreset_stats", {stat_frames0, stat_frames1}, 0);
`endif

    for (int r = 0; r < 2; r++) begin
      do_reset();
      set_pct(30, 80, 70, 70, 60);
      t0 = 0; t1 = 0;
      for (int p = 0; p < 15; p++) begin
        int l;
        l = $urandom_range(1, 4); add_frames(0, l, l); t0 += l;
        l = $urandom_range(1, 4); add_frames(1, l, l); t1 += l;
      end
      drain(5000);
      chk(cnt0 == t0 && cnt1 == t1, "rand_counts", {cnt0[31:0], cnt1[31:0]}, {t0[31:0], t1[31:0]});
      chk(inflight == 0, "rand_inflight", inflight, 0);
`ifdef FFT_SCHED_STATS_EN
      chk(int'(stat_frames0) == cnt0 && int'(stat_frames1) == cnt1, "rand_stats",
          {stat_frames0, stat_frames1}, {cnt0[15:0], cnt1[15:0]});
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
